// File: rtl/q_sys_ram_arbiter_pkg.sv
// Shared constants for the q_sys RAM arbiter: default bus widths, port ids,
// and the width helper for the grant-streak counter.
package q_sys_ram_arb_pkg;

    localparam int ADDR_W_DEF   = 9;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_HOLD_DEF = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/q_sys_ram_arbiter_if.sv
// Avalon-MM bundle around the arbiter: two CPU-side ports plus the RAM side.
// slave = arbiter view, master = view of the CPU masters and the RAM.
interface q_sys_ram_arbiter_if
    import q_sys_ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                  p0_read;
    logic [ADDR_W-1:0]     p0_address;
    logic                  p0_waitrequest;
    logic [DATA_W-1:0]     p0_readdata;
    logic                  p0_readdatavalid;

    logic                  p1_read;
    logic                  p1_write;
    logic [ADDR_W-1:0]     p1_address;
    logic [DATA_W/8-1:0]   p1_byteenable;
    logic [DATA_W-1:0]     p1_writedata;
    logic                  p1_waitrequest;
    logic [DATA_W-1:0]     p1_readdata;
    logic                  p1_readdatavalid;

    logic                  ram_chipselect;
    logic                  ram_write;
    logic [ADDR_W-1:0]     ram_address;
    logic [DATA_W/8-1:0]   ram_byteenable;
    logic [DATA_W-1:0]     ram_writedata;
    logic                  ram_clken;
    logic [DATA_W-1:0]     ram_readdata;

    modport slave (
        input  p0_read, p0_address,
        output p0_waitrequest, p0_readdata, p0_readdatavalid,
        input  p1_read, p1_write, p1_address, p1_byteenable, p1_writedata,
        output p1_waitrequest, p1_readdata, p1_readdatavalid,
        output ram_chipselect, ram_write, ram_address, ram_byteenable,
        output ram_writedata, ram_clken,
        input  ram_readdata
    );

    modport master (
        output p0_read, p0_address,
        input  p0_waitrequest, p0_readdata, p0_readdatavalid,
        output p1_read, p1_write, p1_address, p1_byteenable, p1_writedata,
        input  p1_waitrequest, p1_readdata, p1_readdatavalid,
        input  ram_chipselect, ram_write, ram_address, ram_byteenable,
        input  ram_writedata, ram_clken,
        output ram_readdata
    );

endinterface

// File: rtl/q_sys_ram_arbiter_rr_grant2.sv
// Two-way round-robin grant with a saturating same-port streak counter.
// Grant is combinational from the requests; state updates only on granted cycles.
module q_sys_rr_grant2
    import q_sys_ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    localparam int CNT_W = cnt_width(MAX_HOLD);

    logic             r_last;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_port;

    // On a tie the port that did not win last goes, so a waiter never sits
    // out more than one cycle; the streak counter only grows on solo runs.
    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = (r_last == PORT0) ? 2'b10 : 2'b01;
        end
    end

    assign w_port = o_gnt[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last     <= PORT1;
            r_hold_cnt <= '0;
        end else if (|o_gnt) begin
            r_last <= w_port;
            if (w_port != r_last) begin
                r_hold_cnt <= CNT_W'(1);
            end else if (r_hold_cnt < CNT_W'(MAX_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    a_streak_bound: assert property (@(posedge clk) disable iff (!reset_n)
        !((&i_req) && o_gnt[r_last] && (r_hold_cnt >= CNT_W'(MAX_HOLD))));

endmodule

// File: rtl/q_sys_ram_arbiter.sv
// Shares one single-port RAM between an instruction-fetch port and a data port.
// Losers stall on waitrequest; read data returns one cycle after the grant.
module q_sys_ram_arbiter
    import q_sys_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    q_sys_ram_arbiter_if.slave  bus
);
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rd_issue;
    logic              w_vld0;
    logic              w_vld1;

    logic              r_rd_pend;
    logic              r_rd_port;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    assign w_req = {bus.p1_read | bus.p1_write, bus.p0_read};

    q_sys_rr_grant2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign w_addr             = w_gnt[1] ? bus.p1_address : bus.p0_address;
    assign bus.ram_chipselect = |w_gnt;
    assign bus.ram_write      = w_gnt[1] & bus.p1_write;
    assign bus.ram_address    = w_addr;
    assign bus.ram_byteenable = w_gnt[1] ? bus.p1_byteenable : '1;
    assign bus.ram_writedata  = w_gnt[1] ? bus.p1_writedata : '0;
    assign bus.ram_clken      = 1'b1;

    assign bus.p0_waitrequest = w_req[0] & ~w_gnt[0];
    assign bus.p1_waitrequest = w_req[1] & ~w_gnt[1];

    // A simultaneous read+write on port 1 is treated as a write.
    assign w_rd_issue = w_gnt[0] | (w_gnt[1] & bus.p1_read & ~bus.p1_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rd_port <= PORT0;
        end else begin
            r_rd_pend <= w_rd_issue;
            r_rd_port <= w_gnt[1];
        end
    end

    assign w_vld0 = r_rd_pend & (r_rd_port == PORT0);
    assign w_vld1 = r_rd_pend & (r_rd_port == PORT1);

    // RAM output is only meaningful in the return cycle; keep the last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            if (w_vld0) r_p0_rdata <= bus.ram_readdata;
            if (w_vld1) r_p1_rdata <= bus.ram_readdata;
        end
    end

    assign bus.p0_readdatavalid = w_vld0;
    assign bus.p1_readdatavalid = w_vld1;
    assign bus.p0_readdata      = w_vld0 ? bus.ram_readdata : r_p0_rdata;
    assign bus.p1_readdata      = w_vld1 ? bus.ram_readdata : r_p1_rdata;

    a_p1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.p1_read && bus.p1_write));

endmodule

// File: tb/tb_q_sys_ram_arbiter.sv
// Bench for q_sys_ram_arbiter: RAM stub plus a transaction-level reference
// model (shadow memory, last winner, expected return per cycle).
module tb_q_sys_ram_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    q_sys_ram_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    q_sys_ram_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // RAM stub: one-cycle read latency, byte-lane writes.
    logic [31:0] ram_mem [512];
    always @(posedge clk) begin
        if (bus.ram_chipselect && bus.ram_clken) begin
            if (bus.ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_byteenable[b])
                        ram_mem[bus.ram_address][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
            end else begin
                bus.ram_readdata <= ram_mem[bus.ram_address];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [512];
    int          m_last;
    bit          m_pend;
    int          m_pport;
    logic [31:0] m_pdata;
    logic [31:0] m_hold [2];
    int          g;
    bit          e_vld [2];
    logic [31:0] e_rd [2];

    task automatic model_reset();
        m_last = 1; m_pend = 0; m_pport = 0; m_pdata = '0;
        m_hold[0] = '0; m_hold[1] = '0; g = -1;
    endtask

    // Who should win this cycle and what each port should see returned.
    task automatic predict();
        bit q0, q1;
        q0 = bus.p0_read;
        q1 = bus.p1_read | bus.p1_write;
        if (q0 && q1) g = 1 - m_last;
        else if (q0)  g = 0;
        else if (q1)  g = 1;
        else          g = -1;
        for (int p = 0; p < 2; p++) begin
            e_vld[p] = m_pend && (m_pport == p);
            e_rd[p]  = e_vld[p] ? m_pdata : m_hold[p];
        end
    endtask

    task automatic set_in(input bit r0, input logic [8:0] a0, input bit r1, input bit w1,
                          input logic [8:0] a1, input logic [3:0] be, input logic [31:0] wd);
        bus.p0_read = r0;       bus.p0_address = a0;
        bus.p1_read = r1;       bus.p1_write = w1;
        bus.p1_address = a1;    bus.p1_byteenable = be;
        bus.p1_writedata = wd;
        #1;
        predict();
    endtask

    task automatic tick();
        for (int p = 0; p < 2; p++) if (e_vld[p]) m_hold[p] = m_pdata;
        m_pend = 0;
        if (g >= 0) begin
            m_last = g;
            if (g == 1 && bus.p1_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.p1_byteenable[b])
                        ref_mem[bus.p1_address][b*8 +: 8] = bus.p1_writedata[b*8 +: 8];
            end else begin
                m_pend  = 1;
                m_pport = g;
                m_pdata = ref_mem[(g == 1) ? bus.p1_address : bus.p0_address];
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        tick();
        checks++; if (bus.p0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_vld0 got %b want 0", bus.p0_readdatavalid); end
        checks++; if (bus.p1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_vld1 got %b want 0", bus.p1_readdatavalid); end
        checks++; if (bus.p0_readdata !== 32'h0) begin errors++; $display("FAIL rst_rd0 got %h want 0", bus.p0_readdata); end
        checks++; if (bus.p1_readdata !== 32'h0) begin errors++; $display("FAIL rst_rd1 got %h want 0", bus.p1_readdata); end
        reset_n = 1'b1;
        set_in(1, 9'h033, 0, 0, 9'h0, 4'h0, 32'h0);
        tick();
        reset_n = 1'b0;
        model_reset();
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.p0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_drop_vld got %b want 0", bus.p0_readdatavalid); end
        checks++; if (bus.p0_readdata !== 32'h0) begin errors++; $display("FAIL rst_drop_rd got %h want 0", bus.p0_readdata); end
        tick();
        checks++; if (bus.p0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_hold_vld got %b want 0", bus.p0_readdatavalid); end
        reset_n = 1'b1;
        set_in(1, 9'h011, 1, 0, 9'h022, 4'hF, 32'h0);
        checks++; if (bus.ram_address !== 9'h011) begin errors++; $display("FAIL rst_tie_addr got %h want 011", bus.ram_address); end
        checks++; if (bus.p1_waitrequest !== 1'b1 || bus.p0_waitrequest !== 1'b0) begin
            errors++; $display("FAIL rst_tie_wait got p0=%b p1=%b want p0=0 p1=1", bus.p0_waitrequest, bus.p1_waitrequest); end
        tick();
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        tick();
    endtask

    task automatic test_single_read();
        set_in(1, 9'h010, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.ram_chipselect !== 1'b1 || bus.ram_write !== 1'b0) begin
            errors++; $display("FAIL single_cs got cs=%b we=%b want cs=1 we=0", bus.ram_chipselect, bus.ram_write); end
        checks++; if (bus.ram_address !== 9'h010) begin errors++; $display("FAIL single_addr got %h want 010", bus.ram_address); end
        checks++; if (bus.ram_byteenable !== 4'hF) begin errors++; $display("FAIL single_be got %h want f", bus.ram_byteenable); end
        checks++; if (bus.p0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_wait got %b want 0", bus.p0_waitrequest); end
        tick();
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.p0_readdatavalid !== 1'b1 || bus.p1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL single_vld got p0=%b p1=%b want p0=1 p1=0", bus.p0_readdatavalid, bus.p1_readdatavalid); end
        checks++; if (bus.p0_readdata !== ref_mem[9'h010]) begin errors++; $display("FAIL single_data got %h want %h", bus.p0_readdata, ref_mem[9'h010]); end
        tick();
    endtask

    task automatic test_alternate();
        int          prev_op;
        logic [31:0] prev_data;
        logic [8:0]  a0, a1;
        int          op;
        set_in(0, 9'h0, 1, 0, 9'h0C0, 4'hF, 32'h0);
        tick();
        prev_op = 1;
        prev_data = ref_mem[9'h0C0];
        for (int i = 0; i < 8; i++) begin
            a0 = 9'(9'h040 + i);
            a1 = 9'(9'h0C0 + i);
            set_in(1, a0, 1, 0, a1, 4'hF, 32'h0);
            op = bus.p0_waitrequest ? 1 : 0;
            checks++; if ((bus.p0_waitrequest ^ bus.p1_waitrequest) !== 1'b1) begin
                errors++; $display("FAIL alt_wait[%0d] got p0=%b p1=%b want exactly one", i, bus.p0_waitrequest, bus.p1_waitrequest); end
            checks++; if (op != ((i % 2 == 0) ? 0 : 1)) begin errors++; $display("FAIL alt_grant[%0d] got %0d want %0d", i, op, i % 2); end
            checks++; if ((prev_op ? bus.p1_readdatavalid : bus.p0_readdatavalid) !== 1'b1 ||
                          (prev_op ? bus.p0_readdatavalid : bus.p1_readdatavalid) !== 1'b0) begin
                errors++; $display("FAIL alt_vld[%0d] got p0=%b p1=%b want port %0d only", i, bus.p0_readdatavalid, bus.p1_readdatavalid, prev_op); end
            checks++; if ((prev_op ? bus.p1_readdata : bus.p0_readdata) !== prev_data) begin
                errors++; $display("FAIL alt_data[%0d] got %h want %h", i, prev_op ? bus.p1_readdata : bus.p0_readdata, prev_data); end
            prev_op = op;
            prev_data = ref_mem[op ? a1 : a0];
            tick();
        end
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if ((prev_op ? bus.p1_readdata : bus.p0_readdata) !== prev_data) begin
            errors++; $display("FAIL alt_last got %h want %h", prev_op ? bus.p1_readdata : bus.p0_readdata, prev_data); end
        tick();
    endtask

    task automatic test_hold();
        int p0_done = 0;
        int p1_at = -1;
        bit w;
        for (int c = 0; c < 30 && (p0_done < 8 || p1_at < 0); c++) begin
            w = (c >= 2) && (p1_at < 0);
            set_in(p0_done < 8, 9'(9'h020 + p0_done), 0, w, 9'h1FF, 4'hF, 32'hDEADBEEF);
            if (w && !bus.p1_waitrequest) begin
                p1_at = c;
                checks++; if (bus.ram_write !== 1'b1 || bus.ram_address !== 9'h1FF || bus.ram_writedata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL hold_wr got we=%b a=%h d=%h want 1 1ff deadbeef", bus.ram_write, bus.ram_address, bus.ram_writedata); end
            end
            if (p0_done < 8 && !bus.p0_waitrequest) p0_done++;
            tick();
        end
        checks++; if (p1_at < 0 || p1_at > 2 + MAX_HOLD) begin errors++; $display("FAIL hold_bound got cycle %0d want 2..%0d", p1_at, 2 + MAX_HOLD); end
        checks++; if (p0_done != 8) begin errors++; $display("FAIL hold_stream got %0d reads want 8", p0_done); end
        set_in(0, 9'h0, 1, 0, 9'h1FF, 4'hF, 32'h0);
        tick();
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.p1_readdatavalid !== 1'b1 || bus.p1_readdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold_readback got v=%b d=%h want 1 deadbeef", bus.p1_readdatavalid, bus.p1_readdata); end
        tick();
    endtask

    task automatic test_byte_enable();
        set_in(0, 9'h0, 0, 1, 9'h005, 4'hF, 32'h12345678);
        tick();
        set_in(0, 9'h0, 0, 1, 9'h005, 4'h2, 32'h0000AB00);
        checks++; if (bus.ram_byteenable !== 4'h2 || bus.ram_write !== 1'b1) begin
            errors++; $display("FAIL be_lane got be=%h we=%b want 2 1", bus.ram_byteenable, bus.ram_write); end
        tick();
        set_in(0, 9'h0, 1, 0, 9'h005, 4'hF, 32'h0);
        tick();
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.p1_readdatavalid !== 1'b1 || bus.p1_readdata !== 32'h1234AB78) begin
            errors++; $display("FAIL be_merge got v=%b d=%h want 1 1234ab78", bus.p1_readdatavalid, bus.p1_readdata); end
        tick();
    endtask

    task automatic test_extremes();
        set_in(1, 9'h000, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.ram_address !== 9'h000) begin errors++; $display("FAIL ext_addr0 got %h want 000", bus.ram_address); end
        tick();
        set_in(0, 9'h0, 1, 0, 9'h1FF, 4'hF, 32'h0);
        checks++; if (bus.ram_address !== 9'h1FF) begin errors++; $display("FAIL ext_addr1ff got %h want 1ff", bus.ram_address); end
        checks++; if (bus.p0_readdata !== ref_mem[0]) begin errors++; $display("FAIL ext_data0 got %h want %h", bus.p0_readdata, ref_mem[0]); end
        tick();
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        checks++; if (bus.p1_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ext_data1ff got %h want deadbeef", bus.p1_readdata); end
        tick();
    endtask

    task automatic test_random();
        bit          r0 = 0, r1 = 0, w1 = 0, keep0 = 0, keep1 = 0;
        logic [8:0]  a0 = '0, a1 = '0, ea;
        logic [3:0]  be = '0;
        logic [31:0] wd = '0;
        int          k;
        for (int i = 0; i < 400; i++) begin
            if (!keep0) begin
                r0 = ($urandom_range(0, 2) != 0);
                a0 = 9'($urandom_range(0, 511));
            end
            if (!keep1) begin
                k  = $urandom_range(0, 3);
                r1 = (k == 1);
                w1 = (k >= 2);
                a1 = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 511));
                be = 4'($urandom_range(0, 15));
                wd = $urandom;
            end
            set_in(r0, a0, r1, w1, a1, be, wd);
            ea = (g == 1) ? a1 : a0;
            checks++; if (bus.ram_chipselect !== (g >= 0)) begin errors++; $display("FAIL rnd_cs[%0d] got %b want %b", i, bus.ram_chipselect, g >= 0); end
            checks++; if (g >= 0 && bus.ram_address !== ea) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, bus.ram_address, ea); end
            checks++; if (bus.ram_write !== (g == 1 && w1)) begin errors++; $display("FAIL rnd_we[%0d] got %b want %b", i, bus.ram_write, g == 1 && w1); end
            checks++; if (bus.p0_waitrequest !== (r0 && g != 0)) begin errors++; $display("FAIL rnd_wait0[%0d] got %b want %b", i, bus.p0_waitrequest, r0 && g != 0); end
            checks++; if (bus.p1_waitrequest !== ((r1 || w1) && g != 1)) begin errors++; $display("FAIL rnd_wait1[%0d] got %b want %b", i, bus.p1_waitrequest, (r1 || w1) && g != 1); end
            checks++; if (bus.p0_readdatavalid !== e_vld[0] || bus.p0_readdata !== e_rd[0]) begin
                errors++; $display("FAIL rnd_ret0[%0d] got v=%b d=%h want v=%b d=%h", i, bus.p0_readdatavalid, bus.p0_readdata, e_vld[0], e_rd[0]); end
            checks++; if (bus.p1_readdatavalid !== e_vld[1] || bus.p1_readdata !== e_rd[1]) begin
                errors++; $display("FAIL rnd_ret1[%0d] got v=%b d=%h want v=%b d=%h", i, bus.p1_readdatavalid, bus.p1_readdata, e_vld[1], e_rd[1]); end
            keep0 = r0 && (g != 0);
            keep1 = (r1 || w1) && (g != 1);
            tick();
        end
        set_in(0, 9'h0, 0, 0, 9'h0, 4'h0, 32'h0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
        end
        bus.ram_readdata = '0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_alternate();
        test_hold();
        test_byte_enable();
        test_extremes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
